// File: rtl/seq_gen_pkg.sv
// Shared types and sizing helpers for the 110 serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_e;

  localparam int GAP_CW = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_gen_110_tally.sv
// Counts "110" triplets on the valid bits of a serial stream; saturating count.
module seq_110_tally #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             valid_i,
  output logic [CNT_W-1:0] pat_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Invalid cycles leave the history untouched so patterns may span gaps.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (valid_i) begin
      hist_d = {hist_q[0], bit_i};
      if (!bit_i && (hist_q == 2'b11) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pat_cnt_o = cnt_q;

endmodule

// File: rtl/seq_gen_110.sv
// Serial 110-stream transmitter: loads words by valid/ready, shifts MSB-first.
// Optional build macro SEQ_GEN_LOOP_EN adds loop_en to retransmit the held word.
module seq_gen_110
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop_en,
`endif
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out_seq,
  output logic             out_valid,
  output logic             busy,
  output logic             last_bit,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int                BCW      = clog2(WIDTH);
  localparam logic [BCW-1:0]    BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic              NO_GAP   = (GAP == 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic             armed_q;
  logic             word_end;
  logic             hs;
  logic             loop_go;

`ifdef SEQ_GEN_LOOP_EN
  logic [WIDTH-1:0] hold_q, hold_d;
`endif

  // Last cycle of a word, including its gap; a new word may be accepted here.
  assign word_end = ((state_q == S_SHIFT) && (bit_cnt_q == '0) && NO_GAP) ||
                    ((state_q == S_GAP) && (gap_cnt_q == '0));

  // armed_q keeps load_ready low until the first clock after reset release.
  assign load_ready = armed_q && ((state_q == S_IDLE) || word_end);
  assign hs         = load_valid && load_ready;

`ifdef SEQ_GEN_LOOP_EN
  assign loop_go = word_end && loop_en && !hs;
`else
  assign loop_go = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SEQ_GEN_LOOP_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        shift_d = shift_q << 1;
        if (bit_cnt_q == '0) begin
          if (!NO_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LAST;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - BCW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A handshake wins over looping and over the plain state progression.
    if (hs) begin
      state_d   = S_SHIFT;
      shift_d   = load_data;
      bit_cnt_d = BIT_LAST;
`ifdef SEQ_GEN_LOOP_EN
      hold_d    = load_data;
`endif
    end else if (loop_go) begin
      state_d   = S_SHIFT;
      bit_cnt_d = BIT_LAST;
`ifdef SEQ_GEN_LOOP_EN
      shift_d   = hold_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= 1'b1;
    end
  end

`ifdef SEQ_GEN_LOOP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_SHIFT);
  assign out_seq   = out_valid && shift_q[WIDTH-1];
  assign last_bit  = out_valid && (bit_cnt_q == '0);

  seq_110_tally #(
    .CNT_W (CNT_W)
  ) u_tally (
    .clk       (clk),
    .rst_ni    (reset),
    .bit_i     (out_seq),
    .valid_i   (out_valid),
    .pat_cnt_o (pat_cnt)
  );

endmodule

// File: tb/tb_seq_gen_110.sv
// Directed bench for seq_gen_110: GAP=2 instance (a) and GAP=0 instance (b),
// with a per-bit scoreboard and a reference 110 tally model.
module tb_seq_gen_110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rst_a_n, lv_a, lr_a, os_a, ov_a, busy_a, lb_a, loop_a;
  logic [7:0] ld_a, pc_a;
  logic       rst_b_n, lv_b, lr_b, os_b, ov_b, busy_b, lb_b, loop_b;
  logic [7:0] ld_b, pc_b;

  bit         exp_a[$];
  bit         exp_b[$];
  logic [1:0] hist_a, hist_b;
  int         cnt_a, cnt_b;
  int         run_b, max_run_b;

  seq_gen_110 #(.WIDTH(8), .GAP(2), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .reset      (rst_a_n),
`ifdef SEQ_GEN_LOOP_EN
    .loop_en    (loop_a),
`endif
    .load_valid (lv_a),
    .load_data  (ld_a),
    .load_ready (lr_a),
    .out_seq    (os_a),
    .out_valid  (ov_a),
    .busy       (busy_a),
    .last_bit   (lb_a),
    .pat_cnt    (pc_a)
  );

  seq_gen_110 #(.WIDTH(8), .GAP(0), .CNT_W(8)) u_dut_b (
    .clk        (clk),
    .reset      (rst_b_n),
`ifdef SEQ_GEN_LOOP_EN
    .loop_en    (loop_b),
`endif
    .load_valid (lv_b),
    .load_data  (ld_b),
    .load_ready (lr_b),
    .out_seq    (os_b),
    .out_valid  (ov_b),
    .busy       (busy_b),
    .last_bit   (lb_b),
    .pat_cnt    (pc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected bits of a word and advance the reference tally.
  task automatic push(input int sel, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      if (sel == 0) begin
        exp_a.push_back(d[i]);
        if (!d[i] && hist_a == 2'b11 && cnt_a < 255) cnt_a++;
        hist_a = {hist_a[0], d[i]};
      end else begin
        exp_b.push_back(d[i]);
        if (!d[i] && hist_b == 2'b11 && cnt_b < 255) cnt_b++;
        hist_b = {hist_b[0], d[i]};
      end
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    int t = 0;
    if (sel == 0) begin ld_a = d; lv_a = 1'b1; end
    else          begin ld_b = d; lv_b = 1'b1; end
    while (((sel == 0) ? lr_a : lr_b) !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_within_bound", (t < 100), 1);
    push(sel, d);
    @(posedge clk);
    #1;
    if (sel == 0) lv_a = 1'b0;
    else          lv_b = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int t = 0;
    @(negedge clk);
    while (((sel == 0) ? busy_a : busy_b) === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_within_bound", (t < 300), 1);
  endtask

  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      chk("a_bit_expected", (exp_a.size() > 0), 1);
      if (exp_a.size() > 0) chk("a_out_seq", os_a, exp_a.pop_front());
    end else begin
      chk("a_idle_out_seq", os_a, 0);
    end
  end

  always @(negedge clk) begin
    if (ov_b === 1'b1) begin
      chk("b_bit_expected", (exp_b.size() > 0), 1);
      if (exp_b.size() > 0) chk("b_out_seq", os_b, exp_b.pop_front());
      run_b++;
      if (run_b > max_run_b) max_run_b = run_b;
    end else begin
      run_b = 0;
    end
  end

  initial begin
    rst_a_n = 1'b0; lv_a = 1'b0; ld_a = 8'h00; loop_a = 1'b0;
    rst_b_n = 1'b0; lv_b = 1'b0; ld_b = 8'h00; loop_b = 1'b0;
    hist_a = 2'b00; hist_b = 2'b00; cnt_a = 0; cnt_b = 0;
    run_b = 0; max_run_b = 0;

    // Reset state
    #22;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_seq", os_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_last_bit", lb_a, 0);
    chk("rst_pat_cnt", pc_a, 0);
    chk("rst_load_ready_a", lr_a, 0);
    chk("rst_load_ready_b", lr_b, 0);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready_a", lr_a, 1);
    chk("post_rst_ready_b", lr_b, 1);

    // Single word D8 with two gap cycles
    @(negedge clk);
    send(0, 8'hD8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d8_valid", ov_a, 1);
      chk("d8_last_bit", lb_a, (i == 7));
      chk("d8_ready_in_shift", lr_a, 0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("d8_gap_valid", ov_a, 0);
      chk("d8_gap_busy", busy_a, 1);
      chk("d8_gap_ready", lr_a, (i == 1));
    end
    @(negedge clk);
    chk("d8_idle_busy", busy_a, 0);
    chk("d8_idle_ready", lr_a, 1);
    chk("d8_pat_cnt", pc_a, 2);
    chk("d8_pat_cnt_model", pc_a, cnt_a);

    // GAP=0 back-to-back C0 then 03
    send(1, 8'hC0);
    begin
      int t = 0;
      while (lb_b !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      chk("b_last_bit_seen", (t < 20), 1);
    end
    chk("b_ready_last_shift", lr_b, 1);
    send(1, 8'h03);
    wait_idle(1);
    chk("b_contiguous_bits", max_run_b, 16);
    chk("b_pat_cnt", pc_b, 1);
    chk("b_pat_cnt_model", pc_b, cnt_b);

    // Patterns spanning word boundaries across the gap
    send(0, 8'h01);
    send(0, 8'hC0);
    wait_idle(0);
    chk("span_01_c0", pc_a, 3);
    send(0, 8'h03);
    send(0, 8'h7F);
    wait_idle(0);
    chk("span_03_7f", pc_a, 4);
    chk("span_model", pc_a, cnt_a);

    // Asynchronous reset in the middle of a word
    send(0, 8'hFF);
    repeat (4) @(negedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov_a, 0);
    chk("mid_rst_seq", os_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_pat_cnt", pc_a, 0);
    chk("mid_rst_ready", lr_a, 0);
    exp_a.delete();
    hist_a = 2'b00; cnt_a = 0;
    @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_after", lr_a, 1);
    chk("mid_rst_no_residual", ov_a, 0);

    // Saturation: 130 words of 0110_1101, two triplets each
    for (int i = 0; i < 130; i++) send(0, 8'h6D);
    wait_idle(0);
    chk("sat_pat_cnt", pc_a, 255);
    chk("sat_model", pc_a, cnt_a);

`ifdef SEQ_GEN_LOOP_EN
    // Loop mode: one load of D8 repeats with period 10
    @(negedge clk);
    rst_a_n = 1'b0;
    exp_a.delete();
    hist_a = 2'b00; cnt_a = 0;
    @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
    loop_a = 1'b1;
    send(0, 8'hD8);
    push(0, 8'hD8);
    push(0, 8'hD8);
    push(0, 8'hD8);
    for (int p = 1; p <= 3; p++) begin
      repeat (10) @(negedge clk);
      chk("loop_gap_valid", ov_a, 0);
      chk("loop_pat_cnt", pc_a, 2 * p);
    end
    repeat (2) @(negedge clk);
    loop_a = 1'b0;
    wait_idle(0);
    chk("loop_final_cnt", pc_a, 8);
    chk("loop_model", pc_a, cnt_a);
`endif

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
